// File: rtl/rf_pulse_sequencer_if.sv
// Bundle of the trigger/config inputs and gate/status outputs of the RF pulse sequencer.
interface rf_pulse_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int N_W   = 8
);
  logic             trig;
  logic             abort;
  logic [CNT_W-1:0] t_half;
  logic [CNT_W-1:0] t_gap;
  logic [N_W-1:0]   n_echo;
  logic             rf;
  logic             busy;
  logic             done;
  logic [N_W-1:0]   echo_idx;

  modport master (
    output trig, abort, t_half, t_gap, n_echo,
    input  rf, busy, done, echo_idx
  );

  modport slave (
    input  trig, abort, t_half, t_gap, n_echo,
    output rf, busy, done, echo_idx
  );
endinterface

// File: rtl/rf_pulse_sequencer.sv
// RF pulse sequencer: plays pi/2 - tau - [pi - 2tau]... - pi/2 on a trigger edge.
// n_echo = 0 gives a Ramsey sequence, otherwise a Hahn/CPMG echo train.
// All outputs are registers decoded from the next state, so they line up with the FSM.
module rf_pulse_sequencer #(
  parameter int CNT_W = 16,
  parameter int N_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  rf_pulse_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_P90A, S_GAP_PRE, S_P180, S_GAP_POST, S_P90B
  } state_t;

  localparam logic [CNT_W:0]   C_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [N_W-1:0]   C_EONE = {{(N_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_next;
  logic             r_sync1, r_sync2, r_sync3, r_start;
  logic [CNT_W-1:0] r_th, r_tg;
  logic [N_W-1:0]   r_ne;
  logic [CNT_W:0]   r_cnt, w_load_val;
  logic [CNT_W-1:0] w_th_eff;
  logic [N_W-1:0]   r_echo;
  logic             r_rf, r_busy, r_done;
  logic             w_cnt_zero, w_load, w_rf_d, w_busy_d, w_done_d, w_echo_inc, w_launch;

  // Zero durations are played as one cycle so every state lasts at least a cycle.
  function automatic logic [CNT_W-1:0] f_clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  // pi pulse length, one bit wider so 2*(2^CNT_W-1) never overflows.
  function automatic logic [CNT_W:0] f_double(input logic [CNT_W-1:0] v);
    return {v, 1'b0};
  endfunction

  // Two-flop synchroniser, edge history flop and registered start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_sync1 <= bus.trig;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_start <= r_sync2 & ~r_sync3;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort overrides everything once a sequence is running.
  always_comb begin
    w_cnt_zero = (r_cnt == '0);
    w_next     = r_state;
    if (bus.abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (r_start && !bus.abort) w_next = S_P90A;
        S_P90A:     if (w_cnt_zero) w_next = S_GAP_PRE;
        S_GAP_PRE:  if (w_cnt_zero) w_next = (r_echo == r_ne) ? S_P90B : S_P180;
        S_P180:     if (w_cnt_zero) w_next = S_GAP_POST;
        S_GAP_POST: if (w_cnt_zero) w_next = (r_echo < r_ne) ? S_GAP_PRE : S_P90B;
        S_P90B:     if (w_cnt_zero) w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // Output and counter-load decode from the upcoming state.
  always_comb begin
    w_launch   = (r_state == S_IDLE) && (w_next == S_P90A);
    w_rf_d     = (w_next == S_P90A) || (w_next == S_P180) || (w_next == S_P90B);
    w_busy_d   = (w_next != S_IDLE);
    w_done_d   = (r_state == S_P90B) && (w_next == S_IDLE) && !bus.abort;
    w_echo_inc = (r_state == S_P180) && (w_next == S_GAP_POST);
    w_load     = (w_next != r_state);
    // On launch the config is latched on the same edge, so use the live input.
    w_th_eff   = (r_state == S_IDLE) ? f_clamp1(bus.t_half) : r_th;
    case (w_next)
      S_P90A, S_P90B:        w_load_val = {1'b0, w_th_eff} - C_ONE;
      S_P180:                w_load_val = f_double(w_th_eff) - C_ONE;
      S_GAP_PRE, S_GAP_POST: w_load_val = {1'b0, r_tg} - C_ONE;
      default:               w_load_val = '0;
    endcase
  end

  // Duration counter, echo index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_echo <= '0;
      r_rf   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_load)           r_cnt <= w_load_val;
      else if (!w_cnt_zero) r_cnt <= r_cnt - C_ONE;
      if (w_launch)         r_echo <= '0;
      else if (w_echo_inc)  r_echo <= r_echo + C_EONE;
      r_rf   <= w_rf_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  // Sequence configuration captured at launch; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_th <= f_clamp1(bus.t_half);
      r_tg <= f_clamp1(bus.t_gap);
      r_ne <= bus.n_echo;
    end
  end

  assign bus.rf       = r_rf;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.echo_idx = r_echo;

endmodule
